// File: rtl/lif_step_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : lif_step_scheduler_if
// Brief    : Handshake bundle between the LIF step scheduler, its current
//            source, its spike consumer and the threshold writer.
// Revision : 1.0  initial release
// ============================================================================
interface lif_step_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8,
  parameter int IDX_W     = 2
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 cur_req;
  logic [IDX_W-1:0]     cur_idx;
  logic                 cur_valid;
  logic [WIDTH-1:0]     cur_data;
  logic                 spk_valid;
  logic [IDX_W-1:0]     spk_idx;
  logic                 spk;
  logic [N_NEURONS-1:0] spikes;
  logic                 thr_we;
  logic [WIDTH-1:0]     thr_data;

  // Environment side: stimulus, current source, threshold writer, spike sink
  modport master (
    output start, cur_valid, cur_data, thr_we, thr_data,
    input  busy, done, cur_req, cur_idx, spk_valid, spk_idx, spk, spikes
  );

  // Scheduler side
  modport slave (
    input  start, cur_valid, cur_data, thr_we, thr_data,
    output busy, done, cur_req, cur_idx, spk_valid, spk_idx, spk, spikes
  );
endinterface
`default_nettype wire

// File: rtl/lif_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lif_step_scheduler
// Brief    : One shared leaky integrate-and-fire datapath time-multiplexed
//            over N_NEURONS virtual neurons held in a register file. Each
//            start runs FETCH/UPDATE per neuron, then a one-cycle DONE.
// Options  : LIF_SUBTRACT_RESET_EN - on fire, integrate leak(U - T) instead
//            of zeroing the membrane.
// Revision : 1.0  initial release
// ============================================================================
module lif_step_scheduler #(
  parameter int          N_NEURONS = 4,
  parameter int          WIDTH     = 8,
  parameter int          IDX_W     = 2,
  parameter logic [WIDTH-1:0] THR_RESET = 8'd127
) (
  input  wire                  clk,
  input  wire                  rst,
  lif_step_scheduler_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]     cur_q, cur_d;
  logic [WIDTH-1:0]     thr_q, thr_d;
  logic [WIDTH-1:0]     shd_q, shd_d;
  logic [N_NEURONS-1:0] acc_q, acc_d;
  logic [N_NEURONS-1:0] spikes_q, spikes_d;
  logic [WIDTH-1:0]     mem_q [N_NEURONS];
  logic [WIDTH-1:0]     mem_d [N_NEURONS];

  logic [WIDTH-1:0]     w_u;
  logic                 w_fire;
  logic [WIDTH-1:0]     w_leak_in;
  logic [WIDTH-1:0]     w_leak;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_sat;
  logic [WIDTH-1:0]     w_u_next;

  // LIF arithmetic for the neuron currently addressed by idx_q
  always_comb begin
    w_u    = mem_q[idx_q];
    w_fire = (w_u >= shd_q);
`ifdef LIF_SUBTRACT_RESET_EN
    // fire guarantees U >= T, so the difference cannot wrap
    w_leak_in = w_fire ? (w_u - shd_q) : w_u;
`else
    w_leak_in = w_u;
`endif
    w_leak = (w_leak_in >> 1) + (w_leak_in >> 2) + (w_leak_in >> 3);
    w_sum  = {1'b0, cur_q} + {1'b0, w_leak};
    w_sat  = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`ifdef LIF_SUBTRACT_RESET_EN
    w_u_next = w_sat;
`else
    w_u_next = w_fire ? '0 : w_sat;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH:  if (bus.cur_valid) state_d = S_UPDATE;
      S_UPDATE: state_d = (idx_q == LAST_IDX) ? S_DONE : S_FETCH;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values: index, captured current, thresholds, spike flags, membranes
  always_comb begin
    idx_d    = idx_q;
    cur_d    = cur_q;
    shd_d    = shd_q;
    acc_d    = acc_q;
    spikes_d = spikes_q;
    mem_d    = mem_q;
    thr_d    = bus.thr_we ? bus.thr_data : thr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          idx_d = '0;
          shd_d = thr_q;
          acc_d = '0;
        end
      end
      S_FETCH: begin
        if (bus.cur_valid) cur_d = bus.cur_data;
      end
      S_UPDATE: begin
        mem_d[idx_q] = w_u_next;
        acc_d[idx_q] = w_fire;
        if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
      end
      S_DONE: begin
        spikes_d = acc_q;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      cur_q    <= '0;
      thr_q    <= THR_RESET;
      shd_q    <= THR_RESET;
      acc_q    <= '0;
      spikes_q <= '0;
    end else begin
      idx_q    <= idx_d;
      cur_q    <= cur_d;
      thr_q    <= thr_d;
      shd_q    <= shd_d;
      acc_q    <= acc_d;
      spikes_q <= spikes_d;
    end
  end

  // Membrane register file, one word per virtual neuron
  generate
    for (genvar g = 0; g < N_NEURONS; g++) begin : g_mem
      always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q[g] <= '0;
        else     mem_q[g] <= mem_d[g];
      end
    end
  endgenerate

  // Moore outputs decoded from the state register
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.cur_req   = (state_q == S_FETCH);
    bus.cur_idx   = idx_q;
    bus.spk_valid = (state_q == S_UPDATE);
    bus.spk_idx   = idx_q;
    bus.spk       = (state_q == S_UPDATE) && w_fire;
    bus.spikes    = spikes_q;
  end

endmodule
`default_nettype wire
